// File: rtl/counter_pkg.sv
// Shared types for the rollover period decoder: FSM state encoding.
package counter_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FIRST   = 2'd1,
    S_CONFIRM = 2'd2,
    S_LOCKED  = 2'd3
  } state_e;

endpackage

// File: rtl/ro_period_decoder_if.sv
// Pulse-stream / decode-result bundle between a rollover source and the period decoder.
interface ro_period_decoder_if #(
  parameter int unsigned N = 2
);

  logic         i_clear;
  logic         i_roll_over;
  logic [N-1:0] o_k;
  logic         o_locked;
  logic         o_error;

  modport master (output i_clear, i_roll_over, input o_k, o_locked, o_error);
  modport slave  (input i_clear, i_roll_over, output o_k, o_locked, o_error);

endinterface

// File: rtl/ro_period_cnt.sv
// Saturating cycle counter: restarts at 1 on each pulse, parks at 2^N when pulses stop.
module ro_period_cnt #(
  parameter int unsigned N = 2
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_clear,
  input  logic       i_pulse,
  output logic [N:0] o_cnt
);

  localparam logic [N:0] CNT_MAX = {1'b1, {N{1'b0}}};
  localparam logic [N:0] CNT_ONE = (N+1)'(1);

  logic [N:0] cnt_d, cnt_q;

  // Clear wins over a coincident pulse so that pulse is never measured.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (i_pulse) begin
      cnt_d = CNT_ONE;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_cnt = cnt_q;

endmodule

// File: rtl/ro_period_decoder.sv
// Recovers the modulus of a modulo-k counter from its rollover pulses and tracks lock.
module ro_period_decoder
  import counter_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic         i_clear,
  input  logic         i_roll_over,
  output logic [N-1:0] o_k,
  output logic         o_locked,
  output logic         o_error
);

  localparam logic [N:0] CNT_MAX = {1'b1, {N{1'b0}}};

  logic [N:0]   cnt;
  state_e       state_d, state_q;
  logic [N-1:0] cand_d, cand_q;
  logic [N-1:0] k_d, k_q;
  logic         locked_d, locked_q;
  logic         error_d, error_q;

  logic         timeout_c;
  logic         k_hit_c;
  logic         cand_hit_c;
  logic [N-1:0] period_c;

  ro_period_cnt #(.N(N)) u_cnt (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_clear   (i_clear),
    .i_pulse   (i_roll_over),
    .o_cnt     (cnt)
  );

  // cnt still holds the pre-update value at a pulse edge, i.e. the measured period.
  assign timeout_c  = (cnt == CNT_MAX);
  assign k_hit_c    = (cnt == {1'b0, k_q});
  assign cand_hit_c = (cnt == {1'b0, cand_q});
  assign period_c   = cnt[N-1:0];

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    k_d     = k_q;
    error_d = 1'b0;
    if (i_clear) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (i_roll_over) state_d = S_FIRST;
        end
        S_FIRST, S_CONFIRM: begin
          // A pulse arriving at saturation has an unrepresentable period: flag it, restart from it.
          if (timeout_c) begin
            error_d = 1'b1;
            state_d = i_roll_over ? S_FIRST : S_IDLE;
          end else if (i_roll_over) begin
            if (state_q == S_CONFIRM && cand_hit_c) begin
              state_d = S_LOCKED;
              k_d     = cand_q;
            end else begin
              state_d = S_CONFIRM;
              cand_d  = period_c;
            end
          end
        end
        S_LOCKED: begin
          if (i_roll_over) begin
            if (!k_hit_c) begin
              error_d = 1'b1;
              cand_d  = period_c;
              state_d = S_CONFIRM;
            end
          end else if (k_hit_c) begin
            error_d = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    locked_d = (state_d == S_LOCKED);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= S_IDLE;
      cand_q   <= '0;
      k_q      <= '0;
      locked_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      k_q      <= k_d;
      locked_q <= locked_d;
      error_q  <= error_d;
    end
  end

  assign o_k      = k_q;
  assign o_locked = locked_q;
  assign o_error  = error_q;

endmodule

// File: tb/tb_ro_period_decoder.sv
// Vector-table bench for ro_period_decoder with an expected-output scoreboard queue.
module tb_ro_period_decoder;

  localparam int unsigned N = 2;

  typedef struct {
    logic         clr;
    logic         roll;
    logic         locked;
    logic         error;
    logic [N-1:0] k;
  } vec_t;

  typedef struct {
    logic         locked;
    logic         error;
    logic [N-1:0] k;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;
  vec_t vecs[$];
  exp_t sb_q[$];

  ro_period_decoder_if #(.N(N)) bus ();

  ro_period_decoder #(.N(N)) dut (
    .i_clk       (clk),
    .i_reset_n   (rst_n),
    .i_clear     (bus.i_clear),
    .i_roll_over (bus.i_roll_over),
    .o_k         (bus.o_k),
    .o_locked    (bus.o_locked),
    .o_error     (bus.o_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s step %0d: got %0d, want %0d", name, idx, act, exp);
    end
  endtask

  // Expected values are queued at drive time and retired after the sampling edge.
  task automatic step(input logic clr, input logic roll, input logic el, input logic ee,
                      input logic [N-1:0] ek, input int idx);
    exp_t e;
    @(negedge clk);
    bus.i_clear     = clr;
    bus.i_roll_over = roll;
    e.locked = el;
    e.error  = ee;
    e.k      = ek;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard step %0d: got empty queue, want one entry", idx);
    end else begin
      e = sb_q.pop_front();
      check("o_locked", idx, 8'(bus.o_locked), 8'(e.locked));
      check("o_error",  idx, 8'(bus.o_error),  8'(e.error));
      check("o_k",      idx, 8'(bus.o_k),      8'(e.k));
    end
  endtask

  function automatic void add(input int reps, input logic clr, input logic roll,
                              input logic l, input logic e, input logic [N-1:0] k);
    vec_t v;
    v.clr = clr; v.roll = roll; v.locked = l; v.error = e; v.k = k;
    for (int i = 0; i < reps; i++) vecs.push_back(v);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by t=100000, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n           = 1'b0;
    bus.i_clear     = 1'b0;
    bus.i_roll_over = 1'b0;

    // k=3 lock: pulse every third cycle, lock visible after the third pulse
    add(2, 0, 0, 0, 0, 0); add(1, 0, 1, 0, 0, 0);
    add(2, 0, 0, 0, 0, 0); add(1, 0, 1, 0, 0, 0);
    add(2, 0, 0, 0, 0, 0); add(1, 0, 1, 1, 0, 3);
    add(2, 0, 0, 1, 0, 3); add(1, 0, 1, 1, 0, 3);
    add(2, 0, 0, 1, 0, 3); add(1, 0, 1, 1, 0, 3);
    // early pulse after 2 cycles, then relock at k=2
    add(1, 0, 0, 1, 0, 3); add(1, 0, 1, 0, 1, 3);
    add(1, 0, 0, 0, 0, 3); add(1, 0, 1, 1, 0, 2);
    add(1, 0, 0, 1, 0, 2); add(1, 0, 1, 1, 0, 2);
    // clear, relock at k=3, then omit a pulse (late)
    add(1, 1, 0, 0, 0, 2); add(1, 0, 1, 0, 0, 2);
    add(2, 0, 0, 0, 0, 2); add(1, 0, 1, 0, 0, 2);
    add(2, 0, 0, 0, 0, 2); add(1, 0, 1, 1, 0, 3);
    add(2, 0, 0, 1, 0, 3); add(1, 0, 0, 0, 1, 3);
    add(1, 0, 0, 0, 0, 3);
    // single pulse then silence: timeout when cnt saturates
    add(1, 0, 1, 0, 0, 3); add(3, 0, 0, 0, 0, 3);
    add(1, 0, 0, 0, 1, 3); add(2, 0, 0, 0, 0, 3);
    // roll_over held high: period 1
    add(2, 0, 1, 0, 0, 3); add(3, 0, 1, 1, 0, 1);
    // clear with coincident pulse: pulse ignored, lock one cycle later than otherwise
    add(1, 1, 1, 0, 0, 1); add(2, 0, 1, 0, 0, 1);
    add(1, 0, 1, 1, 0, 1); add(1, 0, 0, 0, 1, 1);
    add(1, 0, 0, 0, 0, 1);
    // relock at k=3 ahead of the reset sequence
    add(1, 0, 1, 0, 0, 1); add(2, 0, 0, 0, 0, 1);
    add(1, 0, 1, 0, 0, 1); add(2, 0, 0, 0, 0, 1);
    add(1, 0, 1, 1, 0, 3);

    #2;
    check("rst_locked", 0, 8'(bus.o_locked), 8'd0);
    check("rst_error",  0, 8'(bus.o_error),  8'd0);
    check("rst_k",      0, 8'(bus.o_k),      8'd0);
    #1 rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i].clr, vecs[i].roll, vecs[i].locked, vecs[i].error, vecs[i].k, i + 1);

    // async reset while locked: outputs drop before any clock edge
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_locked", 100, 8'(bus.o_locked), 8'd0);
    check("async_error",  100, 8'(bus.o_error),  8'd0);
    check("async_k",      100, 8'(bus.o_k),      8'd0);
    step(0, 1, 0, 0, 0, 101);
    rst_n = 1'b1;

    // mid-stream release: partial period ignored, two full periods before lock
    step(0, 0, 0, 0, 0, 102);
    step(0, 1, 0, 0, 0, 103);
    step(0, 0, 0, 0, 0, 104);
    step(0, 0, 0, 0, 0, 105);
    step(0, 1, 0, 0, 0, 106);
    step(0, 0, 0, 0, 0, 107);
    step(0, 0, 0, 0, 0, 108);
    step(0, 1, 1, 0, 3, 109);
    step(0, 0, 1, 0, 3, 110);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
